// File: rtl/spi_slv_burst.sv
// spi_slv_burst: SPI mode-0 slave with burst register access.
// The SPI pins are oversampled in the i_clk domain. Each frame carries an R/W
// bit, an address and then data words until csb rises. Write words may carry
// a CRC-8, and the address can auto-increment from word to word. Read data is
// requested one word ahead so that it is ready to shift out on MISO.
module spi_slv_burst #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CRC_EN   = 1,
  parameter int AUTO_INC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_sclk,
  input  logic              i_spi_csb,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  input  logic              i_spi_slv_en,
  output logic              o_spi_reg_wr_req,
  output logic              o_spi_reg_rd_req,
  output logic [ADDR_W-1:0] o_spi_reg_addr,
  output logic [DATA_W-1:0] o_spi_reg_wdata,
  input  logic              i_reg_spi_wack,
  input  logic              i_reg_spi_rack,
  input  logic [DATA_W-1:0] i_reg_spi_rdata,
  output logic              o_spi_err_vld,
  output logic [1:0]        o_spi_err_code
);

  localparam int HDR_BITS = 1 + ADDR_W;
  localparam int MAX_BITS = (HDR_BITS > DATA_W) ? ((HDR_BITS > 8) ? HDR_BITS : 8)
                                                : ((DATA_W > 8) ? DATA_W : 8);
  localparam int CNT_W = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CRC_LAST  = CNT_W'(7);
  localparam logic [ADDR_W-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RDUMMY, S_RDATA, S_WDATA, S_WCRC
  } state_t;

  // One serial step of CRC-8, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  logic [2:0] sclk_q;
  logic [2:0] csb_q;
  logic [1:0] mosi_q;
  logic       sclk_rise, sclk_fall, csb_rise, csb_fall, mosi_s;

  state_t              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [MAX_BITS-1:0] rx_q;
  logic [7:0]          crc_q;
  logic [DATA_W-1:0]   wbuf_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_pend_q, rd_pend_q, rvalid_q, discard_q;

  logic                miso_q, wr_req_q, rd_req_q, err_vld_q;
  logic [ADDR_W-1:0]   reg_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          err_code_q;

  logic [MAX_BITS-1:0] rx_d;
  logic [7:0]          crc_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [CNT_W-1:0]    bit_cnt_d;
  logic                rack_now;
  logic [DATA_W-1:0]   load_data_d;
  logic                load_miss_d;
  logic                wchk_fire;
  logic [DATA_W-1:0]   wchk_data_d;
  logic                wchk_crc_ok;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign csb_rise  = csb_q[1] & ~csb_q[2];
  assign csb_fall  = ~csb_q[1] & csb_q[2];
  assign mosi_s    = mosi_q[1];

  // Next-value helpers shared by the FSM branches.
  always_comb begin
    rx_d        = {rx_q[MAX_BITS-2:0], mosi_s};
    crc_d       = crc8_step(crc_q, mosi_s);
    addr_d      = addr_q + ADDR_STEP;
    bit_cnt_d   = bit_cnt_q + 1'b1;
    rack_now    = i_reg_spi_rack & rd_pend_q;
    load_miss_d = ~rvalid_q & ~rack_now;
    load_data_d = '0;
    if (rvalid_q)      load_data_d = rbuf_q;
    else if (rack_now) load_data_d = i_reg_spi_rdata;
    wchk_fire   = sclk_rise &&
                  ((state_q == S_WDATA && bit_cnt_q == WORD_LAST && CRC_EN == 0) ||
                   (state_q == S_WCRC  && bit_cnt_q == CRC_LAST));
    wchk_data_d = (state_q == S_WCRC) ? wbuf_q : rx_d[DATA_W-1:0];
    wchk_crc_ok = (state_q != S_WCRC) || (rx_d[7:0] == crc_q);
  end

  // Pin synchronisers. csb resets low so that a reset released mid-frame
  // does not see a false csb fall; the frame is picked up at the next fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_q <= '0;
      csb_q  <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], i_spi_sclk};
      csb_q  <= {csb_q[1:0], i_spi_csb};
      mosi_q <= {mosi_q[0], i_spi_mosi};
    end
  end

  // Frame FSM with registered request, MISO and error outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      crc_q      <= 8'hFF;
      wbuf_q     <= '0;
      tx_q       <= '0;
      rbuf_q     <= '0;
      addr_q     <= '0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      discard_q  <= 1'b0;
      miso_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      reg_addr_q <= '0;
      wdata_q    <= '0;
      err_vld_q  <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      err_vld_q <= 1'b0;

      // Acks are consumed in any active state, including the csb-rise cycle.
      if (state_q != S_IDLE) begin
        if (i_reg_spi_wack) wr_pend_q <= 1'b0;
        if (rack_now) begin
          rd_pend_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rbuf_q    <= i_reg_spi_rdata;
        end
      end

      if (!i_spi_slv_en) begin
        state_q   <= S_IDLE;
        miso_q    <= 1'b0;
        wr_pend_q <= 1'b0;
        rd_pend_q <= 1'b0;
        rvalid_q  <= 1'b0;
      end else if (csb_rise) begin
        state_q   <= S_IDLE;
        miso_q    <= 1'b0;
        wr_pend_q <= 1'b0;
        rd_pend_q <= 1'b0;
        rvalid_q  <= 1'b0;
        if ((state_q == S_HDR || state_q == S_WDATA || state_q == S_WCRC) &&
            bit_cnt_q != '0) begin
          err_vld_q  <= 1'b1;
          err_code_q <= 2'd3;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            miso_q <= 1'b0;
            if (csb_fall) begin
              state_q   <= S_HDR;
              bit_cnt_q <= '0;
              discard_q <= 1'b0;
              wr_pend_q <= 1'b0;
              rd_pend_q <= 1'b0;
              rvalid_q  <= 1'b0;
            end
          end
          S_HDR: begin
            if (sclk_rise) begin
              rx_q <= rx_d;
              if (bit_cnt_q == HDR_LAST) begin
                bit_cnt_q <= '0;
                addr_q    <= rx_d[ADDR_W-1:0];
                if (rx_d[ADDR_W]) begin
                  state_q <= S_WDATA;
                  crc_q   <= 8'hFF;
                end else begin
                  state_q    <= S_RDUMMY;
                  rd_req_q   <= 1'b1;
                  reg_addr_q <= rx_d[ADDR_W-1:0];
                  rd_pend_q  <= 1'b1;
                  rvalid_q   <= 1'b0;
                end
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          S_RDUMMY: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              if (bit_cnt_q == WORD_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= S_RDATA;
                tx_q      <= load_data_d;
                rvalid_q  <= 1'b0;
                rd_pend_q <= 1'b0;
                if (load_miss_d) begin
                  err_vld_q  <= 1'b1;
                  err_code_q <= 2'd2;
                end
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          S_RDATA: begin
            if (sclk_fall) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
              if (bit_cnt_q == '0) begin
                rd_req_q   <= 1'b1;
                reg_addr_q <= addr_d;
                addr_q     <= addr_d;
                rd_pend_q  <= 1'b1;
                rvalid_q   <= 1'b0;
              end
              if (bit_cnt_q == WORD_LAST) begin
                bit_cnt_q <= '0;
                tx_q      <= load_data_d;
                rvalid_q  <= 1'b0;
                rd_pend_q <= 1'b0;
                if (load_miss_d) begin
                  err_vld_q  <= 1'b1;
                  err_code_q <= 2'd2;
                end
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          S_WDATA: begin
            if (sclk_rise) begin
              rx_q  <= rx_d;
              crc_q <= crc_d;
              if (bit_cnt_q == WORD_LAST) begin
                bit_cnt_q <= '0;
                wbuf_q    <= rx_d[DATA_W-1:0];
                if (CRC_EN != 0) state_q <= S_WCRC;
                else             crc_q   <= 8'hFF;
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          S_WCRC: begin
            if (sclk_rise) begin
              rx_q <= rx_d;
              if (bit_cnt_q == CRC_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= S_WDATA;
                crc_q     <= 8'hFF;
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase

        // Write check at the end of a complete word (plus CRC when enabled).
        // After a CRC error the rest of the frame is received but dropped.
        if (wchk_fire) begin
          if (!discard_q) begin
            if (!wchk_crc_ok) begin
              err_vld_q  <= 1'b1;
              err_code_q <= 2'd1;
              discard_q  <= 1'b1;
            end else if (wr_pend_q && !i_reg_spi_wack) begin
              err_vld_q  <= 1'b1;
              err_code_q <= 2'd2;
              wr_pend_q  <= 1'b0;
            end else begin
              wr_req_q   <= 1'b1;
              reg_addr_q <= addr_q;
              wdata_q    <= wchk_data_d;
              wr_pend_q  <= 1'b1;
            end
          end
          addr_q <= addr_d;
        end
      end
    end
  end

  assign o_spi_miso       = miso_q;
  assign o_spi_reg_wr_req = wr_req_q;
  assign o_spi_reg_rd_req = rd_req_q;
  assign o_spi_reg_addr   = reg_addr_q;
  assign o_spi_reg_wdata  = wdata_q;
  assign o_spi_err_vld    = err_vld_q;
  assign o_spi_err_code   = err_code_q;

endmodule

// File: doc/spi_slv_burst.md
# spi_slv_burst

Parametrised successor to the single-register SPI slave. It decodes SPI mode-0 frames carrying a command bit, an address and one or more data words. Frames have an optional per-word CRC-8 and auto-incrementing burst access. The block oversamples the SPI pins in the system clock domain and issues register read/write request pulses to the local register bank, which sits in `lv_core` between the SPI pins and the register file.

## Interface
Parameters:
- `ADDR_W`, 7: register address width.
- `DATA_W`, 8: register data width; also the width of one data word on the wire.
- `CRC_EN`, 1: 1 means each write word is followed by an 8-bit CRC; 0 means no CRC field.
- `AUTO_INC`, 1: 1 means the address increments per word within a frame, wrapping at 2^ADDR_W; 0 means the address is fixed.

Ports (the block has one clock; reset is asynchronous and active-low):
- `i_clk`  in  1  system clock; must run at ≥8× the SPI clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_spi_sclk`  in  1  SPI clock, asynchronous to `i_clk`.
- `i_spi_csb`  in  1  SPI chip select, active low.
- `i_spi_mosi`  in  1  SPI data in.
- `o_spi_miso`  out  1  SPI data out.
- `i_spi_slv_en`  in  1  slave enable.
- `o_spi_reg_wr_req`  out  1  write request, one-cycle pulse.
- `o_spi_reg_rd_req`  out  1  read request, one-cycle pulse.
- `o_spi_reg_addr`  out  ADDR_W  request address; held until the next request.
- `o_spi_reg_wdata`  out  DATA_W  write data; valid with `o_spi_reg_wr_req`.
- `i_reg_spi_wack`  in  1  write acknowledge pulse.
- `i_reg_spi_rack`  in  1  read acknowledge pulse; qualifies `i_reg_spi_rdata`.
- `i_reg_spi_rdata`  in  DATA_W  read data.
- `o_spi_err_vld`  out  1  error pulse.
- `o_spi_err_code`  out  2  error code: 1 = CRC, 2 = ack timeout, 3 = truncated word.

## Operation
- **Input sync:** `sclk`, `csb` and `mosi` each pass through 2-flop synchronisers.
- **Edge detect:** a third `sclk` flop provides rise/fall detection.
- **Sampling:** MOSI is sampled on a detected rise. MISO changes on a detected fall.
- **Frame format:** MSB first, in this order:
  - R/W bit: 1 = write.
  - ADDR_W address bits.
  - Data words until `csb` rises.
- **States:** IDLE, HDR, RDUMMY, RDATA, WDATA, WCRC.
- **IDLE → HDR:** on a `csb` fall while `i_spi_slv_en` = 1. The bit counter clears.
- **HDR:** after 1+ADDR_W bits, the address is latched.
  - Write frames go to WDATA.
  - Read frames issue `o_spi_reg_rd_req` on the next cycle with the latched address, then go to RDUMMY.
- **RDUMMY:** lasts DATA_W bits; MISO = 0.
  - An `i_reg_spi_rack` received before the phase ends loads the shift register.
  - If no rack arrives, the shift register loads 0 and the block pulses error code 2.
- **RDATA:** shifts DATA_W bits out on MISO.
  - At the first bit of each word, the next `rd_req` issues with addr+AUTO_INC. Its rack must arrive before the word ends, otherwise 0 is shifted and error code 2 pulses.
  - Loops until `csb` rises.
- **WDATA:** collects DATA_W bits, then goes to WCRC if `CRC_EN` = 1, otherwise straight to the write check.
- **WCRC:** collects 8 bits. The received value is compared with CRC-8 over the word's DATA_W data bits only:
  - polynomial 0x07;
  - initial value 0xFF;
  - no reflection;
  - no final XOR.
- **Write check:**
  - CRC matches (or `CRC_EN` = 0): `o_spi_reg_wr_req` pulses next cycle with the current address and the word.
  - Mismatch: error code 1 pulses, no write is issued, and all remaining words in the frame are discarded (receive only, no requests).
- **Write acknowledge:** `i_reg_spi_wack` must arrive before the next word completes. If not, error code 2 pulses and that next word is discarded.
- **Address increment:** after each word when `AUTO_INC` = 1. Arithmetic is modulo 2^ADDR_W, so 0x7F → 0x00 for ADDR_W = 7.
- **End of frame:** a `csb` rise in any state returns to IDLE.
  - If it lands mid-word (bit count not 0) in WDATA, WCRC or HDR, error code 3 pulses and no request is issued.
  - A `csb` rise in RDATA mid-word is not an error.
- **Slave disable:** `i_spi_slv_en` = 0 forces IDLE immediately, even mid-frame, with no error pulse. Frames that start while disabled are ignored entirely.
- **Simultaneous events:** an ack and a `csb` rise in the same cycle: the ack is consumed and the frame ends. An ack arriving in IDLE is ignored.

## Timing
- **Reset values:** all outputs are 0, state is IDLE.
- **Input latency:** 3 `i_clk` cycles from a pin edge to its internal event.
- **`rd_req`:** 1 cycle after the last address-bit rise event.
- **`wr_req`:** 1 cycle after the last data or CRC rise event.
- **MISO:** registered; updates 1 cycle after a detected fall. In IDLE it drives 0.
- **Error pulses:** `o_spi_err_vld` is a single cycle. `o_spi_err_code` holds its value until the next error.
- **Mid-operation reset:** reset asserted mid-frame clears everything immediately. The block resynchronises on the next `csb` fall.

## Test plan
- **Single write:** CRC_EN = 1, addr 0x12, data 0xA5 with the correct CRC-8 → one `wr_req` with addr 0x12 and wdata 0xA5; no error.
- **Bad CRC burst:** write burst 3 words at addr 0x7E, middle word with a bad CRC → a `wr_req` to 0x7E, error code 1, no further writes.
- **Read burst with wrap:** 2 words at addr 0x7F, rack with 0x3C then 0xC3 → `rd_req` to 0x7F then 0x00; MISO carries 0x00 (dummy), 0x3C, 0xC3.
- **Read timeout:** read with rack withheld → MISO data 0x00 and error code 2.
- **Truncated frame:** `csb` rises after 4 data bits of a write → error code 3, no `wr_req`.
- **Disable and reset:** `i_spi_slv_en` dropped mid-header, then `i_rst_n` pulsed mid-frame → IDLE, outputs 0, no requests; the next valid frame is decoded correctly.
